fsk_modulator: RTL and testbench
================================

FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 Parameter BIT_CYCLES, default 64: sysclk cycles per transmitted bit.
REQ-002 Parameter MARK_HALF, default 1: half-period of the mark (logic 1) tone, in sysclk cycles.
REQ-003 Parameter SPACE_HALF, default 4: half-period of the space (logic 0) tone, in sysclk cycles.
REQ-004 sysclk  input  1  sole clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit; sampled only on handshake.
REQ-007 tx_valid  input  1  tx_data holds a valid byte.
REQ-008 tx_ready  output  1  the block can accept a byte this cycle.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 signal_out  output  1  FSK square-wave line output.

Function
REQ-011 A handshake occurs on a cycle with tx_valid=1 and tx_ready=1; tx_data is latched on that edge.
REQ-012 tx_ready SHALL be 1 only in IDLE and not under reset.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
REQ-014 Transitions: IDLE->START on handshake; START->DATA after BIT_CYCLES; DATA->PARITY or STOP after 8 bits; PARITY->STOP; STOP->IDLE after BIT_CYCLES.
REQ-015 The frame is: start bit = space, 8 data bits LSB first, optional parity bit, stop bit = mark.
REQ-016 The START bit begins on the cycle after the handshake.
REQ-017 Every bit occupies exactly BIT_CYCLES cycles.
REQ-018 busy=1 from START entry until the last STOP cycle inclusive.
REQ-019 IDLE emits a continuous mark tone.
REQ-020 Tone generation: a half-period counter counts 0..HALF-1, where HALF is the current bit's MARK_HALF or SPACE_HALF; signal_out toggles on the cycle the counter reaches HALF-1, and the counter then wraps to 0.
REQ-021 At each bit boundary the half-period counter restarts at 0 and signal_out is not forced, so the output stays phase-continuous.
REQ-022 tx_valid and tx_data are ignored while busy; there is no queueing.
REQ-023 Back-to-back frames: with tx_valid held high, the next handshake occurs on the single IDLE cycle following STOP, giving a 1-cycle mark gap.
REQ-024 Counter widths: the bit-cycle counter is $clog2(BIT_CYCLES) bits; the bit index is 4 bits; all counters wrap-free, cleared on state change.
REQ-025 Legal parameters: MARK_HALF>=1, SPACE_HALF>MARK_HALF, BIT_CYCLES>=4*SPACE_HALF; other values are unsupported.

Reset
REQ-026 While reset=1 the outputs are: signal_out=0, tx_ready=0, busy=0; the FSM is in IDLE and all counters are 0.
REQ-027 Reset asserted mid-frame aborts the frame with no partial stop bit.
REQ-028 tx_ready=1 and the mark tone begins on the first cycle after reset deasserts.

Configuration
REQ-029 Macro FSK_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) is sent as a PARITY state between DATA and STOP, giving a frame of 11*BIT_CYCLES cycles.
REQ-030 Without FSK_PARITY_EN, no PARITY state or logic exists and the frame is 10*BIT_CYCLES cycles.

Structure
REQ-031 Shared package fsk_pkg SHALL hold the FSM state enum, the default BIT_CYCLES, MARK_HALF and SPACE_HALF constants, and the 16-cycle demodulation window and edge-threshold constants, so the modulator and demodulator agree.
REQ-032 Sub-module fsk_tone_gen SHALL contain the half-period counter and toggle flop, with inputs for bit value and bit-boundary restart.

Verification (defaults; a 16-cycle window counts 8 rising edges for mark and 2 for space)
REQ-033 Reset, then 200 idle cycles -> signal_out toggles every cycle, tx_ready=1, busy=0.
REQ-034 Send 0xA5 -> 64 cycles of period-8 tone (start), then bits 1,0,1,0,0,1,0,1 (mark/space), then 64 cycles of mark; busy high for 640 cycles.
REQ-035 Send 0x00 then 0xFF with tx_valid held high -> second START begins exactly 641 cycles after the first START.
REQ-036 Pulse tx_valid with 0x3C during a frame -> ignored; only the original frame is emitted.
REQ-037 Assert reset at frame cycle 300 -> signal_out=0 and busy=0 while in reset; tx_ready=1 and mark tone on the first cycle after deassertion.
REQ-038 With FSK_PARITY_EN, send 0x07 -> parity bit = 1 (mark) and frame length 704 cycles; looped through a window-edge-count checker (>5 edges = 1), the decoded bits match.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared constants and FSM state type for the FSK modulator and its matching demodulator.
// Optional parity support is enabled by defining FSK_PARITY_EN.
package fsk_pkg;

    localparam int DEF_BIT_CYCLES = 64;
    localparam int DEF_MARK_HALF  = 1;
    localparam int DEF_SPACE_HALF = 4;

    // Demodulator window: 8 rising edges per window for mark, 2 for space.
    localparam int DEMOD_WINDOW   = 16;
    localparam int EDGE_THRESHOLD = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FSK_PARITY_EN
        PARITY,
`endif
        STOP
    } fsk_state_t;

`ifdef FSK_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/fsk_tone_gen.sv
// Phase-continuous square-wave generator: half-period counter plus toggle flop.
// The restart input zeroes the counter at a bit boundary without touching the output level.
module fsk_tone_gen
    import fsk_pkg::*;
#(
    parameter int MARK_HALF  = DEF_MARK_HALF,
    parameter int SPACE_HALF = DEF_SPACE_HALF
) (
    input  logic sysclk,
    input  logic reset,
    input  logic bit_val,
    input  logic restart,
    output logic signal_out
);

    localparam int CW = (SPACE_HALF > 1) ? $clog2(SPACE_HALF) : 1;
    localparam logic [CW-1:0] MARK_LAST  = CW'(MARK_HALF - 1);
    localparam logic [CW-1:0] SPACE_LAST = CW'(SPACE_HALF - 1);

    logic [CW-1:0] half_cnt;
    logic [CW-1:0] cur_cnt;
    logic [CW-1:0] half_last;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        cur_cnt   = restart ? '0 : half_cnt;
        half_last = bit_val ? MARK_LAST : SPACE_LAST;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            half_cnt   <= '0;
            signal_out <= 1'b0;
        end else if (cur_cnt == half_last) begin
            half_cnt   <= '0;
            signal_out <= ~signal_out;
        end else begin
            half_cnt   <= cur_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fsk_modulator.sv
// FSK byte modulator: start(space), 8 data bits LSB first, optional even parity, stop(mark).
// Define FSK_PARITY_EN to insert the parity bit between DATA and STOP.
module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int MARK_HALF  = DEF_MARK_HALF,
    parameter int SPACE_HALF = DEF_SPACE_HALF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       signal_out
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

    fsk_state_t    state;
    logic [CW-1:0] bit_cyc;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic          first_cyc;
    logic          bit_val;
    logic          bit_last;
`ifdef FSK_PARITY_EN
    logic          parity_bit;
`endif

    // Gated by reset so the block is ready on the very first cycle after reset drops.
    assign tx_ready = (state == IDLE) && !reset;
    assign bit_last = (bit_cyc == LAST_CYC);

    always_comb begin
        bit_val = 1'b1;
        case (state)
            START:   bit_val = 1'b0;
            DATA:    bit_val = shreg[0];
`ifdef FSK_PARITY_EN
            PARITY:  bit_val = parity_bit;
`endif
            default: bit_val = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cyc    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            first_cyc  <= 1'b0;
`ifdef FSK_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            first_cyc <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state      <= START;
                        shreg      <= tx_data;
                        busy       <= 1'b1;
                        bit_cyc    <= '0;
                        first_cyc  <= 1'b1;
`ifdef FSK_PARITY_EN
                        parity_bit <= even_parity(tx_data);
`endif
                    end
                end
                START: begin
                    if (bit_last) begin
                        state     <= DATA;
                        bit_cyc   <= '0;
                        first_cyc <= 1'b1;
                    end else begin
                        bit_cyc   <= bit_cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cyc   <= '0;
                        first_cyc <= 1'b1;
                        shreg     <= {1'b0, shreg[7:1]};
                        if (bit_idx == 4'd7) begin
                            bit_idx <= '0;
`ifdef FSK_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cyc <= bit_cyc + 1'b1;
                    end
                end
`ifdef FSK_PARITY_EN
                PARITY: begin
                    if (bit_last) begin
                        state     <= STOP;
                        bit_cyc   <= '0;
                        first_cyc <= 1'b1;
                    end else begin
                        bit_cyc   <= bit_cyc + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_last) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_cyc   <= '0;
                        first_cyc <= 1'b1;
                    end else begin
                        bit_cyc   <= bit_cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fsk_tone_gen #(
        .MARK_HALF  (MARK_HALF),
        .SPACE_HALF (SPACE_HALF)
    ) u_tone (
        .sysclk     (sysclk),
        .reset      (reset),
        .bit_val    (bit_val),
        .restart    (first_cyc),
        .signal_out (signal_out)
    );

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator: expected frame bits are queued on each handshake
// and compared against a window edge-count demodulator plus per-bit toggle counts.
module tb_fsk_modulator;
    import fsk_pkg::*;

    localparam int BITC = DEF_BIT_CYCLES;
`ifdef FSK_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME  = NBITS * BITC;
    localparam int WIN_LO = 8;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       busy;
    logic       signal_out;

    always #5 sysclk = ~sysclk;

    fsk_modulator dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .signal_out (signal_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic sb_q[$];
    int   start_q[$];
    int   cyc = 0;

    always @(posedge sysclk) cyc++;

    // Output monitor: demodulates each bit and checks tone rate and frame length.
    int   fc = -1;
    int   tog = 0;
    int   edges = 0;
    int   busy_len = 0;
    int   aborts = 0;
    logic prev_sig = 1'b0;
    logic prev_busy = 1'b0;
    logic cur_exp = 1'b1;

    always @(negedge sysclk) begin
        if (reset) begin
            if (fc >= 0) aborts++;
            fc = -1;
            sb_q.delete();
        end else if (fc < 0) begin
            if (busy && !prev_busy) begin
                fc       = 0;
                tog      = 0;
                edges    = 0;
                busy_len = 1;
                start_q.push_back(cyc);
            end
        end else begin
            fc++;
            if (signal_out != prev_sig) tog++;
            if ((fc % BITC) > WIN_LO && (fc % BITC) <= WIN_LO + DEMOD_WINDOW
                && signal_out && !prev_sig) edges++;
            if ((fc % BITC) == WIN_LO + DEMOD_WINDOW) begin
                if (sb_q.size() == 0) begin
                    check("sb_pending", sb_q.size(), 1);
                end else begin
                    cur_exp = sb_q.pop_front();
                    check("bit", edges > EDGE_THRESHOLD, cur_exp);
                end
                edges = 0;
            end
            if ((fc % BITC) == 0) begin
                check("tone_toggles", tog, cur_exp ? BITC / DEF_MARK_HALF : BITC / DEF_SPACE_HALF);
                tog = 0;
            end
            if (busy) busy_len++;
            if (fc == FRAME) begin
                check("busy_len", busy_len, FRAME);
                fc = -1;
            end
        end
        prev_sig  = signal_out;
        prev_busy = busy;
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [7:0] d, input bit keep);
        int w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && w < 2 * FRAME) begin
            @(posedge sysclk);
            #1;
            w++;
        end
        if (!tx_ready) begin
            check("tmo_ready", tx_ready, 1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge sysclk);
        sb_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb_q.push_back(d[i]);
`ifdef FSK_PARITY_EN
        sb_q.push_back(^d);
`endif
        sb_q.push_back(1'b1);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int w = 0;
        int rb = 0;
        @(negedge sysclk);
        while ((fc >= 0 || busy) && w < 3 * FRAME) begin
            if (busy && tx_ready) rb++;
            @(negedge sysclk);
            w++;
        end
        check("frame_end", (fc < 0) && !busy, 1);
        check("ready_in_frame", rb, 0);
        check("sb_left", sb_q.size(), 0);
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        logic prev;
        int   n_tog;
        int   n_rdy;
        int   n_busy;

        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_sig", signal_out, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", busy, 0);

        reset = 1'b0;
        #1;
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_sig", signal_out, 0);

        // Idle mark tone: one toggle per cycle.
        prev   = signal_out;
        n_tog  = 0;
        n_rdy  = 0;
        n_busy = 0;
        repeat (200) begin
            @(posedge sysclk);
            #1;
            if (signal_out != prev) n_tog++;
            if (tx_ready) n_rdy++;
            if (busy) n_busy++;
            prev = signal_out;
        end
        check("idle_toggles", n_tog, 200);
        check("idle_ready", n_rdy, 200);
        check("idle_busy", n_busy, 0);

        send(8'hA5, 1'b0);
        wait_frame();

        // Back-to-back with tx_valid held high.
        start_q.delete();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        wait_frame();
        check("b2b_starts", start_q.size(), 2);
        if (start_q.size() >= 2) check("b2b_spacing", start_q[1] - start_q[0], FRAME + 1);

        // A request during a frame must be dropped.
        send(8'h5A, 1'b0);
        repeat (100) @(posedge sysclk);
        #1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge sysclk);
        #1;
        tx_valid = 1'b0;
        wait_frame();
        n_busy = 0;
        repeat (20) begin
            @(posedge sysclk);
            #1;
            if (busy) n_busy++;
        end
        check("no_queued_frame", n_busy, 0);

        send(8'h07, 1'b0);
        wait_frame();

        // Mid-frame reset abort.
        aborts = 0;
        send(8'hC3, 1'b0);
        repeat (299) @(posedge sysclk);
        #1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge sysclk);
            #1;
            check("abort_busy", busy, 0);
            check("abort_sig", signal_out, 0);
            check("abort_ready", tx_ready, 0);
        end
        reset = 1'b0;
        #1;
        check("rec_ready", tx_ready, 1);
        check("rec_busy", busy, 0);
        check("rec_sig0", signal_out, 0);
        @(posedge sysclk);
        #1;
        check("rec_sig1", signal_out, 1);
        @(posedge sysclk);
        #1;
        check("rec_sig2", signal_out, 0);
        check("aborts", aborts, 1);

        send(8'h81, 1'b0);
        wait_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
